// File: rtl/lane_dist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lane_dist_pkg                                                    |
// | Brief   : Shared constants, lane-index type and helpers for lane_dist_n.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lane_dist_pkg;

  localparam logic [3:0] D_SEL_TRANSPORT = 4'h8;
  localparam int         MAX_LANES       = 4;
  localparam int         LANE_IDX_W      = $clog2(MAX_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // Index of the highest active lane: NUM_LANES-1 when bonded, lane 0 otherwise.
  function automatic lane_idx_t last_lane(input logic bonded, input int num_lanes);
    return bonded ? lane_idx_t'(num_lanes - 1) : lane_idx_t'(0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_dist_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lane_dist_n_if                                                   |
// | Brief   : Valid/ready stream bundle used on every lane_dist_n data port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lane_dist_n_if #(
  parameter int W = 8
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/lane_dist_rx_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lane_dist_rx_unpack                                              |
// | Brief   : RX word register and byte unpacker; LANE_DIST_ERR_EN adds        |
// |           the sticky rx_overrun flag.                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lane_dist_rx_unpack
  import lane_dist_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 transport_i,
  input  lane_idx_t            last_i,
  lane_dist_n_if.slave         rx_in_i,
  lane_dist_n_if.master        rx_out_o
`ifdef LANE_DIST_ERR_EN
  ,
  output logic                 rx_overrun_o
`endif
);

  localparam int WORD_W = NUM_LANES * DATA_W;

  logic [WORD_W-1:0] word_q, word_d;
  lane_idx_t         cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              w_emit, w_in_ready, w_acc;

  // cnt_q counts bytes still to follow the one currently presented.
  assign w_emit     = valid_q && rx_out_o.ready;
  assign w_in_ready = enable_i && (!valid_q || (w_emit && (cnt_q == '0)));
  assign w_acc      = rx_in_i.valid && w_in_ready;

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (w_emit) begin
      if (cnt_q == '0) begin
        valid_d = 1'b0;
      end else begin
        word_d = word_q >> DATA_W;
        cnt_d  = cnt_q - lane_idx_t'(1);
      end
    end
    if (w_acc) begin
      word_d  = rx_in_i.data;
      cnt_d   = transport_i ? last_i : lane_idx_t'(0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (!enable_i) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign rx_in_i.ready  = w_in_ready;
  assign rx_out_o.data  = word_q[DATA_W-1:0];
  assign rx_out_o.valid = valid_q;

`ifdef LANE_DIST_ERR_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (!enable_i) begin
      overrun_q <= 1'b0;
    end else if (rx_in_i.valid && !w_in_ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign rx_overrun_o = overrun_q;
`endif

endmodule
`default_nettype wire

// File: rtl/lane_dist_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lane_dist_n                                                      |
// | Brief   : N-lane TX distributer / RX merger, single clock, valid/ready.    |
// |           Define LANE_DIST_ERR_EN for the rx_overrun error flag.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lane_dist_n
  import lane_dist_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_t_i,
  input  logic          enable_r_i,
  input  logic [3:0]    d_sel_i,
  input  logic          bonded_i,
  lane_dist_n_if.slave  tx_in_i,
  lane_dist_n_if.master tx_out_o,
  lane_dist_n_if.slave  rx_in_i,
  lane_dist_n_if.master rx_out_o,
  output logic          enable_enc_o,
  output logic          rx_lanes_on_o
`ifdef LANE_DIST_ERR_EN
  ,
  output logic          rx_overrun_o
`endif
);

  localparam int WORD_W = NUM_LANES * DATA_W;

  logic [WORD_W-1:0] asm_q, asm_d, out_q, out_d;
  lane_idx_t         idx_q, idx_d;
  logic              asm_full_q, asm_full_d, out_valid_q, out_valid_d;
  logic              enc_q, en_t_q, bonded_t_q, bonded_r_q, lanes_on_q;

  logic              w_bonded_t, w_bonded_r, w_transport;
  lane_idx_t         w_last_t, w_last_r;
  logic              w_out_free, w_move, w_flush, w_in_ready, w_acc, w_complete;
  logic [WORD_W-1:0] w_word;

  // The bonded bit is taken live in the first enabled cycle so that cycle's traffic already uses it.
  assign w_bonded_t  = (enable_t_i && !en_t_q) ? bonded_i : bonded_t_q;
  assign w_bonded_r  = (enable_r_i && !lanes_on_q) ? bonded_i : bonded_r_q;
  assign w_last_t    = last_lane(w_bonded_t, NUM_LANES);
  assign w_last_r    = last_lane(w_bonded_r, NUM_LANES);
  assign w_transport = (d_sel_i == D_SEL_TRANSPORT);

  assign w_out_free  = !out_valid_q || tx_out_o.ready;
  assign w_move      = asm_full_q && w_out_free;
  assign w_flush     = enable_t_i && !asm_full_q && (idx_q != '0) && !w_transport;
  assign w_in_ready  = enable_t_i && !w_flush && !(asm_full_q && !w_out_free);
  assign w_acc       = tx_in_i.valid && w_in_ready;

  always_comb begin
    asm_d       = asm_q;
    idx_d       = idx_q;
    asm_full_d  = asm_full_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !tx_out_o.ready;
    w_word      = w_move ? '0 : asm_q;
    w_complete  = 1'b0;
    if (w_move) begin
      out_d       = asm_q;
      out_valid_d = 1'b1;
      asm_d       = '0;
      asm_full_d  = 1'b0;
    end
    if (w_acc) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (w_transport ? (lane_idx_t'(k) == idx_q) : (lane_idx_t'(k) <= w_last_t)) begin
          w_word[k*DATA_W +: DATA_W] = tx_in_i.data;
        end
      end
      w_complete = !w_transport || (idx_q == w_last_t);
      idx_d      = w_complete ? lane_idx_t'(0) : idx_q + lane_idx_t'(1);
      asm_d      = w_word;
    end else if (w_flush) begin
      w_complete = 1'b1;
      idx_d      = '0;
    end
    // A finished word bypasses the assembly register whenever the output slot is free.
    if (w_complete) begin
      if (!w_move && w_out_free) begin
        out_d       = w_word;
        out_valid_d = 1'b1;
        asm_d       = '0;
        asm_full_d  = 1'b0;
      end else begin
        asm_d      = w_word;
        asm_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      idx_q       <= '0;
      asm_full_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      enc_q       <= 1'b0;
      en_t_q      <= 1'b0;
      bonded_t_q  <= 1'b0;
    end else if (!enable_t_i) begin
      asm_q       <= '0;
      idx_q       <= '0;
      asm_full_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      enc_q       <= 1'b0;
      en_t_q      <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      asm_full_q  <= asm_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_q || (out_valid_q && tx_out_o.ready);
      en_t_q      <= 1'b1;
      bonded_t_q  <= w_bonded_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_on_q <= 1'b0;
      bonded_r_q <= 1'b0;
    end else begin
      lanes_on_q <= enable_r_i;
      if (enable_r_i) begin
        bonded_r_q <= w_bonded_r;
      end
    end
  end

  assign tx_in_i.ready  = w_in_ready;
  assign tx_out_o.data  = out_q;
  assign tx_out_o.valid = out_valid_q;
  assign enable_enc_o   = enc_q;
  assign rx_lanes_on_o  = lanes_on_q;

  lane_dist_rx_unpack #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W)
  ) u_rx_unpack (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_r_i),
    .transport_i  (w_transport),
    .last_i       (w_last_r),
    .rx_in_i      (rx_in_i),
    .rx_out_o     (rx_out_o)
`ifdef LANE_DIST_ERR_EN
    ,
    .rx_overrun_o (rx_overrun_o)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_lane_dist_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lane_dist_n                                                   |
// | Brief   : Directed self-checking bench for lane_dist_n (2 lanes, 8 bits).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lane_dist_n;

  localparam int NL = 2;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_t, enable_r, bonded;
  logic [3:0] d_sel;
  logic       enable_enc, rx_lanes_on;
`ifdef LANE_DIST_ERR_EN
  logic       rx_overrun;
`endif
  int checks = 0;
  int errors = 0;

  lane_dist_n_if #(.W(DW))      tx_in  ();
  lane_dist_n_if #(.W(NL * DW)) tx_out ();
  lane_dist_n_if #(.W(NL * DW)) rx_in  ();
  lane_dist_n_if #(.W(DW))      rx_out ();

  always #5 clk = ~clk;

  lane_dist_n #(.NUM_LANES(NL), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_t_i    (enable_t),
    .enable_r_i    (enable_r),
    .d_sel_i       (d_sel),
    .bonded_i      (bonded),
    .tx_in_i       (tx_in),
    .tx_out_o      (tx_out),
    .rx_in_i       (rx_in),
    .rx_out_o      (rx_out),
    .enable_enc_o  (enable_enc),
    .rx_lanes_on_o (rx_lanes_on)
`ifdef LANE_DIST_ERR_EN
    ,
    .rx_overrun_o  (rx_overrun)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_t = 1'b0; enable_r = 1'b0; bonded = 1'b1; d_sel = 4'h8;
    tx_in.valid = 1'b0; tx_in.data = '0; tx_out.ready = 1'b0;
    rx_in.valid = 1'b0; rx_in.data = '0; rx_out.ready = 1'b0;
    tick(); tick(); settle();
    checks++; if (tx_in.ready !== 1'b0) begin errors++; $display("FAIL rst_tx_in_ready got %b exp 0", tx_in.ready); end
    checks++; if (tx_out.valid !== 1'b0) begin errors++; $display("FAIL rst_tx_out_valid got %b exp 0", tx_out.valid); end
    checks++; if (tx_out.data !== 16'h0000) begin errors++; $display("FAIL rst_tx_out_data got %h exp 0000", tx_out.data); end
    checks++; if (rx_in.ready !== 1'b0) begin errors++; $display("FAIL rst_rx_in_ready got %b exp 0", rx_in.ready); end
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL rst_rx_out_valid got %b exp 0", rx_out.valid); end
    checks++; if (enable_enc !== 1'b0) begin errors++; $display("FAIL rst_enable_enc got %b exp 0", enable_enc); end
    checks++; if (rx_lanes_on !== 1'b0) begin errors++; $display("FAIL rst_rx_lanes_on got %b exp 0", rx_lanes_on); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tx_transport();
    enable_t = 1'b1; bonded = 1'b1; d_sel = 4'h8; tx_out.ready = 1'b1;
    tx_in.valid = 1'b1; tx_in.data = 8'hA1; settle();
    checks++; if (tx_in.ready !== 1'b1) begin errors++; $display("FAIL txb_in_ready got %b exp 1", tx_in.ready); end
    tick(); tx_in.data = 8'hB2; settle();
    tick(); tx_in.data = 8'hC3; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'hB2A1}) begin errors++; $display("FAIL txb_word0 got %b/%h exp 1/b2a1", tx_out.valid, tx_out.data); end
    checks++; if (enable_enc !== 1'b0) begin errors++; $display("FAIL txb_enc_early got %b exp 0", enable_enc); end
    tick(); tx_in.data = 8'hD4; settle();
    checks++; if (enable_enc !== 1'b1) begin errors++; $display("FAIL txb_enc_rise got %b exp 1", enable_enc); end
    checks++; if (tx_out.valid !== 1'b0) begin errors++; $display("FAIL txb_gap_valid got %b exp 0", tx_out.valid); end
    tick(); tx_in.valid = 1'b0; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'hD4C3}) begin errors++; $display("FAIL txb_word1 got %b/%h exp 1/d4c3", tx_out.valid, tx_out.data); end
    tick(); settle();
    checks++; if (tx_out.valid !== 1'b0) begin errors++; $display("FAIL txb_idle_valid got %b exp 0", tx_out.valid); end
    enable_t = 1'b0;
    tick(); settle();
    checks++; if (enable_enc !== 1'b0) begin errors++; $display("FAIL txb_enc_clear got %b exp 0", enable_enc); end
    checks++; if (tx_in.ready !== 1'b0) begin errors++; $display("FAIL txb_off_ready got %b exp 0", tx_in.ready); end
  endtask

  task automatic test_tx_single();
    logic [7:0] b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    enable_t = 1'b1; bonded = 1'b0; d_sel = 4'h8; tx_out.ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        tx_in.valid = 1'b1; tx_in.data = b[i];
      end else begin
        tx_in.valid = 1'b0;
      end
      settle();
      if (i > 0) begin
        checks++;
        if ({tx_out.valid, tx_out.data} !== {1'b1, 8'h00, b[i-1]}) begin
          errors++; $display("FAIL txs_word%0d got %b/%h exp 1/00%h", i - 1, tx_out.valid, tx_out.data, b[i-1]);
        end
      end
      tick();
    end
    enable_t = 1'b0; bonded = 1'b1;
    tick();
  endtask

  task automatic test_tx_flush();
    enable_t = 1'b1; bonded = 1'b1; d_sel = 4'h8; tx_out.ready = 1'b1;
    tx_in.valid = 1'b1; tx_in.data = 8'h5A; settle();
    tick(); d_sel = 4'h2; tx_in.data = 8'h3C; settle();
    checks++; if (tx_in.ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", tx_in.ready); end
    tick(); settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'h005A}) begin errors++; $display("FAIL flush_word got %b/%h exp 1/005a", tx_out.valid, tx_out.data); end
    checks++; if (tx_in.ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b exp 1", tx_in.ready); end
    tick(); tx_in.valid = 1'b0; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'h3C3C}) begin errors++; $display("FAIL os_word got %b/%h exp 1/3c3c", tx_out.valid, tx_out.data); end
    tick();
    enable_t = 1'b0; d_sel = 4'h8;
    tick();
  endtask

  task automatic test_tx_stall();
    enable_t = 1'b1; bonded = 1'b1; d_sel = 4'h8; tx_out.ready = 1'b0;
    tx_in.valid = 1'b1; tx_in.data = 8'h01; settle();
    tick(); tx_in.data = 8'h02;
    tick(); tx_in.data = 8'h03;
    tick(); tx_in.data = 8'h04; settle();
    checks++; if (tx_in.ready !== 1'b1) begin errors++; $display("FAIL stall_partial_ready got %b exp 1", tx_in.ready); end
    tick(); tx_in.data = 8'h05; settle();
    checks++; if (tx_in.ready !== 1'b0) begin errors++; $display("FAIL stall_ready_drop got %b exp 0", tx_in.ready); end
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'h0201}) begin errors++; $display("FAIL stall_word0 got %b/%h exp 1/0201", tx_out.valid, tx_out.data); end
    tick(); settle();
    checks++; if (tx_in.ready !== 1'b0) begin errors++; $display("FAIL stall_ready_hold got %b exp 0", tx_in.ready); end
    checks++; if (tx_out.data !== 16'h0201) begin errors++; $display("FAIL stall_data_hold got %h exp 0201", tx_out.data); end
    tx_out.ready = 1'b1; settle();
    checks++; if (tx_in.ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", tx_in.ready); end
    tick(); tx_in.data = 8'h06; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'h0403}) begin errors++; $display("FAIL stall_word1 got %b/%h exp 1/0403", tx_out.valid, tx_out.data); end
    tick(); tx_in.valid = 1'b0; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'h0605}) begin errors++; $display("FAIL stall_word2 got %b/%h exp 1/0605", tx_out.valid, tx_out.data); end
    tick(); settle();
    checks++; if (tx_out.valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b exp 0", tx_out.valid); end
    enable_t = 1'b0;
    tick();
  endtask

  task automatic test_rx_transport();
    enable_r = 1'b1; bonded = 1'b1; d_sel = 4'h8; rx_out.ready = 1'b0;
    rx_in.valid = 1'b1; rx_in.data = 16'h2211; settle();
    checks++; if (rx_in.ready !== 1'b1) begin errors++; $display("FAIL rx_idle_ready got %b exp 1", rx_in.ready); end
    checks++; if (rx_lanes_on !== 1'b0) begin errors++; $display("FAIL rx_lanes_on_early got %b exp 0", rx_lanes_on); end
    tick(); rx_in.valid = 1'b0; settle();
    checks++; if (rx_lanes_on !== 1'b1) begin errors++; $display("FAIL rx_lanes_on got %b exp 1", rx_lanes_on); end
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rx_byte0 got %b/%h exp 1/11", rx_out.valid, rx_out.data); end
    tick(); rx_out.ready = 1'b1; settle();
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL rx_byte0_hold got %b/%h exp 1/11", rx_out.valid, rx_out.data); end
    checks++; if (rx_in.ready !== 1'b0) begin errors++; $display("FAIL rx_busy_ready got %b exp 0", rx_in.ready); end
    tick(); rx_out.ready = 1'b0; settle();
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL rx_byte1 got %b/%h exp 1/22", rx_out.valid, rx_out.data); end
    checks++; if (rx_in.ready !== 1'b0) begin errors++; $display("FAIL rx_last_stall_ready got %b exp 0", rx_in.ready); end
    tick(); rx_out.ready = 1'b1; settle();
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL rx_byte1_hold got %b/%h exp 1/22", rx_out.valid, rx_out.data); end
    checks++; if (rx_in.ready !== 1'b1) begin errors++; $display("FAIL rx_last_hs_ready got %b exp 1", rx_in.ready); end
    tick(); settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL rx_done_valid got %b exp 0", rx_out.valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    rx_out.ready = 1'b1; rx_in.valid = 1'b1; rx_in.data = 16'h4433; settle();
    tick(); rx_in.data = 16'h6655;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rx_in.valid = 1'b0;
      settle();
      checks++;
      if ({rx_out.valid, rx_out.data} !== {1'b1, e[i]}) begin
        errors++; $display("FAIL b2b_byte%0d got %b/%h exp 1/%h", i, rx_out.valid, rx_out.data, e[i]);
      end
      tick();
    end
    settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", rx_out.valid); end
    d_sel = 4'h2; rx_in.valid = 1'b1; rx_in.data = 16'h8877; settle();
    tick(); rx_in.valid = 1'b0; settle();
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h77}) begin errors++; $display("FAIL rx_os_byte got %b/%h exp 1/77", rx_out.valid, rx_out.data); end
    tick(); settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL rx_os_end got %b exp 0", rx_out.valid); end
    d_sel = 4'h8;
    enable_r = 1'b0; tick();
    enable_r = 1'b1; bonded = 1'b0; rx_in.valid = 1'b1; rx_in.data = 16'hAABB; settle();
    tick(); rx_in.valid = 1'b0; bonded = 1'b1; settle();
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL rx_single_byte got %b/%h exp 1/bb", rx_out.valid, rx_out.data); end
    tick(); settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL rx_single_end got %b exp 0", rx_out.valid); end
    enable_r = 1'b0; tick();
  endtask

  task automatic test_rx_disable();
    enable_r = 1'b1; bonded = 1'b1; d_sel = 4'h8; rx_out.ready = 1'b0;
    rx_in.valid = 1'b1; rx_in.data = 16'h2211; settle();
    tick(); rx_in.data = 16'h9999; settle();
    checks++; if (rx_in.ready !== 1'b0) begin errors++; $display("FAIL dis_busy_ready got %b exp 0", rx_in.ready); end
    tick(); settle();
`ifdef LANE_DIST_ERR_EN
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", rx_overrun); end
`endif
    checks++; if ({rx_out.valid, rx_out.data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL dis_keep_byte got %b/%h exp 1/11", rx_out.valid, rx_out.data); end
    rx_in.valid = 1'b0; enable_r = 1'b0;
    tick(); settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b exp 0", rx_out.valid); end
    checks++; if (rx_lanes_on !== 1'b0) begin errors++; $display("FAIL dis_lanes_on got %b exp 0", rx_lanes_on); end
`ifdef LANE_DIST_ERR_EN
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", rx_overrun); end
`endif
    enable_r = 1'b1; rx_out.ready = 1'b1;
    tick(); settle();
    checks++; if (rx_out.valid !== 1'b0) begin errors++; $display("FAIL dis_no_stale got %b exp 0", rx_out.valid); end
    enable_r = 1'b0;
    tick();
  endtask

  task automatic test_reset_midword();
    enable_t = 1'b1; bonded = 1'b1; d_sel = 4'h8; tx_out.ready = 1'b1;
    tx_in.valid = 1'b1; tx_in.data = 8'h77; settle();
    tick(); tx_in.valid = 1'b0; rst_n = 1'b0; settle();
    checks++; if (tx_out.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", tx_out.valid); end
    tick(); rst_n = 1'b1;
    tx_in.valid = 1'b1; tx_in.data = 8'hE1;
    tick(); tx_in.data = 8'hF2;
    tick(); tx_in.valid = 1'b0; settle();
    checks++; if ({tx_out.valid, tx_out.data} !== {1'b1, 16'hF2E1}) begin errors++; $display("FAIL midrst_word got %b/%h exp 1/f2e1", tx_out.valid, tx_out.data); end
    enable_t = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_transport();
    test_tx_single();
    test_tx_flush();
    test_tx_stall();
    test_rx_transport();
    test_back_to_back();
    test_rx_disable();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
